// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the control sequencer: state encoding and the
// default write/request-enable mask matching the decoder's control-word
// bit order (low byte carries register/memory write and bus request enables).
package seq_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2,
        IRQ  = 2'd3
    } seq_state_t;

    localparam logic [21:0] SEQ_WE_MASK_DEFAULT = 22'h0000FF;

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer
// Counts consecutive memory wait cycles and flags the cycle on which the
// count reaches WAIT_TIMEOUT. WAIT_TIMEOUT = 0 never times out.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clear     restart count (entering a wait)
//   i_count     one more wait cycle elapses this clock
//   o_timeout   this wait cycle reaches the limit (combinational)
module seq_wait_timer #(
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam int unsigned CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign o_timeout = (WAIT_TIMEOUT != 0) && i_count && (w_cnt_inc == CW'(WAIT_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Owns the multicycle step counter and gates the decoder's control word
// against memory wait-states, halt and global enable.
// Optional macro SEQ_IRQ_EN adds interrupt entry (IRQ state, pending latch).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ena               global enable; low freezes all state, masks writes
//   ctrl_i / ctrl_o   raw / gated control word
//   step_done_i       current step is the last of the instruction
//   mem_req_i         current step accesses memory
//   mem_ready_i       memory completes the access this cycle
//   halt_req_i        halt at the next instruction boundary
//   step_o            current step to decoder
//   stall_o           write enables suppressed this cycle
//   halted_o          in HALT
//   bus_err_o         sticky wait timeout
//   seq_err_o         sticky step overflow
//   irq_i, irq_active_o, irq_ack_o   (SEQ_IRQ_EN only)
//
// state | meaning
// RUN   | stepping through an instruction
// WAIT  | step held until memory ready or timeout
// HALT  | parked at step 0, writes masked, until halt_req_i drops
// IRQ   | decoder running the interrupt entry microsequence
module ctrl_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned              STEP_WIDTH    = 3,
    parameter int unsigned              CONTROL_WIDTH = 22,
    parameter logic [CONTROL_WIDTH-1:0] WE_MASK       = CONTROL_WIDTH'(SEQ_WE_MASK_DEFAULT),
    parameter int unsigned              WAIT_TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [CONTROL_WIDTH-1:0] ctrl_i,
    input  logic                     step_done_i,
    input  logic                     mem_req_i,
    input  logic                     mem_ready_i,
    input  logic                     halt_req_i,
`ifdef SEQ_IRQ_EN
    input  logic                     irq_i,
    output logic                     irq_active_o,
    output logic                     irq_ack_o,
`endif
    output logic [STEP_WIDTH-1:0]    step_o,
    output logic [CONTROL_WIDTH-1:0] ctrl_o,
    output logic                     stall_o,
    output logic                     halted_o,
    output logic                     bus_err_o,
    output logic                     seq_err_o
);

    seq_state_t            r_state, w_state_nxt;
    logic [STEP_WIDTH-1:0] r_step, w_step_nxt;
    logic                  r_bus_err, w_bus_err_nxt;
    logic                  r_seq_err, w_seq_err_nxt;
    logic                  w_mem_stall;
    logic                  w_stall;
    logic                  w_timer_clear;
    logic                  w_timer_count;
    logic                  w_timeout;

    assign w_mem_stall = mem_req_i & ~mem_ready_i;
    // Reset is folded into the mask so nothing is written while rst_n is low,
    // even though the registers already read back as RUN/step 0.
    assign w_stall = ~rst_n | ~ena | (r_state == HALT) | w_mem_stall;

    assign w_timer_clear = ena & w_mem_stall & (r_state != WAIT) & (r_state != HALT);
    assign w_timer_count = ena & w_mem_stall & (r_state == WAIT);

    seq_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_count  (w_timer_count),
        .o_timeout(w_timeout)
    );

`ifdef SEQ_IRQ_EN
    // r_irq_ctx stays set through waits so WAIT knows to return to IRQ.
    logic r_irq_ctx, w_irq_ctx_nxt;
    logic r_pend, w_pend_nxt;
    logic w_ack;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_bus_err_nxt = r_bus_err;
        w_seq_err_nxt = r_seq_err;
`ifdef SEQ_IRQ_EN
        w_irq_ctx_nxt = r_irq_ctx;
        w_pend_nxt    = r_pend;
        w_ack         = 1'b0;
`endif
        if (ena) begin
`ifdef SEQ_IRQ_EN
            if (irq_i && !r_irq_ctx) begin
                w_pend_nxt = 1'b1;
            end
`endif
            case (r_state)
                HALT: begin
                    if (!halt_req_i) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    if (w_timeout) begin
                        w_bus_err_nxt = 1'b1;
                        w_step_nxt    = '0;
                        w_state_nxt   = RUN;
`ifdef SEQ_IRQ_EN
                        w_irq_ctx_nxt = 1'b0;
`endif
                    end else if (w_mem_stall) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = RUN;
`ifdef SEQ_IRQ_EN
                        if (r_irq_ctx) begin
                            w_state_nxt = IRQ;
                        end
`endif
                        if (step_done_i) begin
                            w_step_nxt = '0;
`ifdef SEQ_IRQ_EN
                            if (r_irq_ctx) begin
                                w_ack         = 1'b1;
                                w_pend_nxt    = 1'b0;
                                w_irq_ctx_nxt = 1'b0;
                                w_state_nxt   = RUN;
                            end else if (halt_req_i) begin
                                w_state_nxt = HALT;
                            end else if (r_pend) begin
                                w_irq_ctx_nxt = 1'b1;
                                w_state_nxt   = IRQ;
                            end
`else
                            if (halt_req_i) begin
                                w_state_nxt = HALT;
                            end
`endif
                        end else if (r_step == '1) begin
                            w_seq_err_nxt = 1'b1;
                            w_step_nxt    = '0;
                        end else begin
                            w_step_nxt = r_step + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_step    <= '0;
            r_bus_err <= 1'b0;
            r_seq_err <= 1'b0;
`ifdef SEQ_IRQ_EN
            r_irq_ctx <= 1'b0;
            r_pend    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_bus_err <= w_bus_err_nxt;
            r_seq_err <= w_seq_err_nxt;
`ifdef SEQ_IRQ_EN
            r_irq_ctx <= w_irq_ctx_nxt;
            r_pend    <= w_pend_nxt;
`endif
        end
    end

    assign step_o    = r_step;
    assign ctrl_o    = w_stall ? (ctrl_i & ~WE_MASK) : ctrl_i;
    assign stall_o   = w_stall;
    assign halted_o  = (r_state == HALT);
    assign bus_err_o = r_bus_err;
    assign seq_err_o = r_seq_err;
`ifdef SEQ_IRQ_EN
    assign irq_active_o = r_irq_ctx;
    assign irq_ack_o    = w_ack;
`endif

endmodule
